// File: rtl/adsr_pkg.sv
// ============================================================================
// Module : adsr_pkg
// Brief  : Shared state encoding, limits and step helper for the ADSR envelope.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package adsr_pkg;

  localparam int          ENV_BITS = 16;
  localparam logic [15:0] ENV_MAX  = 16'hFFFF;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ATTACK  = 3'd1,
    ST_DECAY   = 3'd2,
    ST_SUSTAIN = 3'd3,
    ST_RELEASE = 3'd4
  } adsr_state_t;

  // A zero rate is promoted to 1 so every phase always makes progress.
  function automatic logic [15:0] form_step(input logic [7:0] rate, input int unsigned shift);
    logic [15:0] w_base;
    w_base = {8'h00, (rate == 8'h00) ? 8'h01 : rate};
    return w_base << shift;
  endfunction

endpackage

`default_nettype wire

// File: rtl/adsr_sat_step.sv
// ============================================================================
// Module : adsr_sat_step
// Brief  : Saturating add/subtract against a ceiling/floor, with a limit flag.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module adsr_sat_step #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] i_value,
  input  logic [WIDTH-1:0] i_step,
  input  logic [WIDTH-1:0] i_limit,
  input  logic             i_sub,
  output logic [WIDTH-1:0] o_value,
  output logic             o_hit
);

  logic [WIDTH:0] w_sum;
  logic [WIDTH:0] w_diff;

  assign w_sum  = {1'b0, i_value} + {1'b0, i_step};
  assign w_diff = {1'b0, i_value} - {1'b0, i_step};

  // A borrow out of the subtraction counts as reaching the floor, so nothing wraps.
  always_comb begin
    o_hit   = 1'b0;
    o_value = i_value;
    if (i_sub) begin
      o_hit = (i_value <= i_limit) || w_diff[WIDTH] || (w_diff[WIDTH-1:0] <= i_limit);
    end else begin
      o_hit = (w_sum >= {1'b0, i_limit});
    end
    if (o_hit) begin
      o_value = i_limit;
    end else if (i_sub) begin
      o_value = w_diff[WIDTH-1:0];
    end else begin
      o_value = w_sum[WIDTH-1:0];
    end
  end

endmodule

`default_nettype wire

// File: rtl/adsr_envelope_unit.sv
// ============================================================================
// Module : adsr_envelope_unit
// Brief  : Beat-stepped linear ADSR envelope; ADSR_STATE_PORT_EN adds env_state.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module adsr_envelope_unit
  import adsr_pkg::*;
#(
  parameter int ENV_W      = 16,
  parameter int STEP_SHIFT = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             play_enable,
  input  logic             beat,
  input  logic [7:0]       attack,
  input  logic [7:0]       decay,
  input  logic [7:0]       sustain,
  input  logic [7:0]       released,
  output logic [ENV_W-1:0] envelope_out
`ifdef ADSR_STATE_PORT_EN
  ,
  output logic [2:0]       env_state
`endif
);

  generate
    if (ENV_W != ENV_BITS || STEP_SHIFT > 8) begin : g_param_check
      $error("adsr_envelope_unit: ENV_W must be 16 and STEP_SHIFT at most 8");
    end
  endgenerate

  adsr_state_t      r_state;
  adsr_state_t      w_state_nxt;
  logic [ENV_W-1:0] r_env;
  logic [ENV_W-1:0] w_env_nxt;
  logic [ENV_W-1:0] w_sustain_level;
  logic [ENV_W-1:0] w_step;
  logic [ENV_W-1:0] w_limit;
  logic [ENV_W-1:0] w_sat_val;
  logic             w_sub;
  logic             w_hit;

  assign w_sustain_level = {sustain, 8'h00};

  // Rates and sustain are used live: whatever is on the inputs at the beat applies.
  always_comb begin
    w_step  = form_step(attack, STEP_SHIFT);
    w_limit = ENV_MAX;
    w_sub   = 1'b0;
    case (r_state)
      ST_DECAY: begin
        w_step  = form_step(decay, STEP_SHIFT);
        w_limit = w_sustain_level;
        w_sub   = 1'b1;
      end
      ST_RELEASE: begin
        w_step  = form_step(released, STEP_SHIFT);
        w_limit = '0;
        w_sub   = 1'b1;
      end
      default: ;
    endcase
  end

  adsr_sat_step #(
    .WIDTH (ENV_W)
  ) u_sat_step (
    .i_value (r_env),
    .i_step  (w_step),
    .i_limit (w_limit),
    .i_sub   (w_sub),
    .o_value (w_sat_val),
    .o_hit   (w_hit)
  );

  // Gate edges take priority; a beat in the same cycle is dropped.
  always_comb begin
    w_state_nxt = r_state;
    w_env_nxt   = r_env;
    if (play_enable && (r_state == ST_IDLE || r_state == ST_RELEASE)) begin
      w_state_nxt = ST_ATTACK;
    end else if (!play_enable && (r_state == ST_ATTACK || r_state == ST_DECAY ||
                                  r_state == ST_SUSTAIN)) begin
      w_state_nxt = ST_RELEASE;
    end else if (beat) begin
      case (r_state)
        ST_ATTACK: begin
          w_env_nxt = w_sat_val;
          if (w_hit) w_state_nxt = ST_DECAY;
        end
        ST_DECAY: begin
          w_env_nxt = w_sat_val;
          if (w_hit) w_state_nxt = ST_SUSTAIN;
        end
        ST_SUSTAIN: begin
          w_env_nxt = w_sustain_level;
        end
        ST_RELEASE: begin
          w_env_nxt = w_sat_val;
          if (w_hit) w_state_nxt = ST_IDLE;
        end
        default: begin
          w_env_nxt   = '0;
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_env   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_env   <= w_env_nxt;
    end
  end

  assign envelope_out = r_env;

`ifdef ADSR_STATE_PORT_EN
  assign env_state = r_state;
`endif

endmodule

`default_nettype wire

// File: tb/tb_adsr_envelope_unit.sv
// ============================================================================
// Module : tb_adsr_envelope_unit
// Brief  : Scoreboard bench for adsr_envelope_unit against a behavioural model.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_adsr_envelope_unit;

  localparam int M_IDLE = 0, M_ATTACK = 1, M_DECAY = 2, M_SUSTAIN = 3, M_RELEASE = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        play_enable = 1'b0;
  logic        beat = 1'b0;
  logic [7:0]  attack = 8'd0;
  logic [7:0]  decay = 8'd0;
  logic [7:0]  sustain = 8'd0;
  logic [7:0]  released = 8'd0;
  logic [15:0] envelope_out;

  int tests_run = 0;
  int tests_failed = 0;
  int m_state = M_IDLE;
  int m_env = 0;
  int sb_q[$];

  adsr_envelope_unit #(
    .ENV_W      (16),
    .STEP_SHIFT (8)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .play_enable  (play_enable),
    .beat         (beat),
    .attack       (attack),
    .decay        (decay),
    .sustain      (sustain),
    .released     (released),
    .envelope_out (envelope_out)
  );

  always #5 clk = ~clk;

  function automatic int rate_step(input logic [7:0] r);
    return ((r == 8'd0) ? 1 : int'(r)) * 256;
  endfunction

  // Reference behaviour for one rising edge, using the inputs as they stand now.
  task automatic model_step();
    int lvl;
    int nv;
    lvl = int'(sustain) * 256;
    if (play_enable && (m_state == M_IDLE || m_state == M_RELEASE)) begin
      m_state = M_ATTACK;
    end else if (!play_enable && (m_state == M_ATTACK || m_state == M_DECAY || m_state == M_SUSTAIN)) begin
      m_state = M_RELEASE;
    end else if (beat) begin
      case (m_state)
        M_ATTACK: begin
          nv = m_env + rate_step(attack);
          if (nv >= 65535) begin m_env = 65535; m_state = M_DECAY; end
          else m_env = nv;
        end
        M_DECAY: begin
          nv = m_env - rate_step(decay);
          if (m_env <= lvl || nv <= lvl) begin m_env = lvl; m_state = M_SUSTAIN; end
          else m_env = nv;
        end
        M_SUSTAIN: m_env = lvl;
        M_RELEASE: begin
          if (m_env <= rate_step(released)) begin m_env = 0; m_state = M_IDLE; end
          else m_env = m_env - rate_step(released);
        end
        default: m_env = 0;
      endcase
    end
  endtask

  task automatic cycle(input logic b);
    int exp;
    @(negedge clk);
    beat = b;
    model_step();
    sb_q.push_back(m_env);
    @(posedge clk);
    #1;
    beat = 1'b0;
    exp = sb_q.pop_front();
    tests_run++;
    if (envelope_out !== exp[15:0]) begin
      tests_failed++;
      $display("FAIL scoreboard t=%0t got=%0d expected=%0d", $time, envelope_out, exp);
    end
  endtask

  task automatic expect_env(input string name, input int exp);
    tests_run++;
    if (envelope_out !== exp[15:0]) begin
      tests_failed++;
      $display("FAIL %s got=%0d expected=%0d", name, envelope_out, exp);
    end
  endtask

  task automatic test_reset();
    #12;
    expect_env("reset_value", 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    m_state = M_IDLE;
    m_env = 0;
    for (int i = 0; i < 4; i++) cycle(1'b1);
    expect_env("idle_beats", 0);
  endtask

  task automatic test_attack();
    attack = 8'd10;
    play_enable = 1'b1;
    cycle(1'b0);
    cycle(1'b1);
    expect_env("attack_first", 2560);
    for (int i = 2; i <= 25; i++) cycle(1'b1);
    expect_env("attack_25", 64000);
    cycle(1'b1);
    expect_env("attack_sat", 65535);
  endtask

  task automatic test_decay_sustain();
    decay = 8'd10;
    sustain = 8'd128;
    for (int i = 1; i <= 12; i++) cycle(1'b1);
    expect_env("decay_12", 34815);
    cycle(1'b1);
    expect_env("decay_clamp", 32768);
    cycle(1'b1);
    cycle(1'b0);
    cycle(1'b1);
    expect_env("sustain_hold", 32768);
  endtask

  task automatic test_release();
    released = 8'd20;
    play_enable = 1'b0;
    cycle(1'b1);
    expect_env("release_gate_hold", 32768);
    cycle(1'b1);
    expect_env("release_first", 27648);
    for (int i = 2; i <= 6; i++) cycle(1'b1);
    expect_env("release_6", 2048);
    cycle(1'b1);
    expect_env("release_zero", 0);
    cycle(1'b1);
    expect_env("idle_after_release", 0);
  endtask

  task automatic test_retrigger();
    attack = 8'd255;
    decay = 8'd255;
    sustain = 8'd128;
    play_enable = 1'b1;
    cycle(1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b1);
    expect_env("fast_to_sustain", 32768);
    play_enable = 1'b0;
    released = 8'd20;
    cycle(1'b0);
    cycle(1'b1);
    cycle(1'b1);
    expect_env("release_mid", 22528);
    attack = 8'd5;
    play_enable = 1'b1;
    cycle(1'b1);
    expect_env("retrigger_hold", 22528);
    cycle(1'b1);
    expect_env("retrigger_step", 23808);
  endtask

  task automatic test_mid_phase();
    attack = 8'd40;
    cycle(1'b1);
    expect_env("attack_40", 34048);
    attack = 8'd5;
    cycle(1'b1);
    expect_env("attack_5", 35328);
    attack = 8'd255;
    cycle(1'b1);
    expect_env("attack_to_max", 65535);
    decay = 8'd10;
    sustain = 8'd128;
    for (int i = 0; i < 6; i++) cycle(1'b1);
    expect_env("decay_6", 50175);
    sustain = 8'd200;
    cycle(1'b1);
    expect_env("sustain_raise", 51200);
  endtask

  task automatic test_rate_zero();
    released = 8'd0;
    play_enable = 1'b0;
    cycle(1'b0);
    cycle(1'b1);
    expect_env("release_rate0", 50944);
    attack = 8'd0;
    play_enable = 1'b1;
    cycle(1'b0);
    cycle(1'b1);
    expect_env("attack_rate0", 51200);
    attack = 8'd255;
    cycle(1'b1);
    decay = 8'd0;
    cycle(1'b1);
    expect_env("decay_rate0", 65279);
  endtask

  task automatic test_reset_mid_note();
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    expect_env("async_reset", 0);
    m_state = M_IDLE;
    m_env = 0;
    @(posedge clk);
    #1;
    attack = 8'd3;
    play_enable = 1'b1;
    reset = 1'b0;
    cycle(1'b1);
    expect_env("post_reset_gate", 0);
    cycle(1'b1);
    expect_env("post_reset_attack", 768);
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 19) == 0) play_enable = ~play_enable;
      if ($urandom_range(0, 7) == 0) attack = 8'($urandom_range(0, 60));
      if ($urandom_range(0, 7) == 0) decay = 8'($urandom_range(0, 60));
      if ($urandom_range(0, 7) == 0) sustain = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 7) == 0) released = 8'($urandom_range(0, 60));
      cycle(1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    test_reset();
    test_attack();
    test_decay_sustain();
    test_release();
    test_retrigger();
    test_mid_phase();
    test_rate_zero();
    test_reset_mid_note();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

`default_nettype wire
